// File: rtl/wishbone_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_arbiter_2
//  Purpose  : Two-master to one-slave Wishbone arbiter. A registered grant
//             FSM picks one master (round-robin or fixed priority), locks the
//             grant for as long as that master holds cyc, and routes the
//             granted master's request to the slave port. Slave responses go
//             back to the granted master only. Read data is broadcast to both
//             masters. An optional watchdog answers a strobe that the slave
//             never acknowledges with a one-cycle error.
//
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             wbm0_* / wbm1_*        - Wishbone slave-side ports for master 0/1
//                                      (adr/dat/we/sel/stb/cyc in,
//                                       dat/ack/err/rty out)
//             wbs_*                  - Wishbone master-side port to the slave
//                                      (adr/dat/we/sel/stb/cyc out,
//                                       dat/ack/err/rty in)
//
//  Revision : 1.0 - initial release
// ============================================================================
module wishbone_arbiter_2 #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
   parameter int ARB_ROUND_ROBIN = 1,
   parameter int TIMEOUT         = 0
) (
   input  logic                    clk,
   input  logic                    rst,

   // master 0
   input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
   input  logic                    wbm0_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
   input  logic                    wbm0_stb_i,
   output logic                    wbm0_ack_o,
   output logic                    wbm0_err_o,
   output logic                    wbm0_rty_o,
   input  logic                    wbm0_cyc_i,

   // master 1
   input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
   input  logic                    wbm1_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
   input  logic                    wbm1_stb_i,
   output logic                    wbm1_ack_o,
   output logic                    wbm1_err_o,
   output logic                    wbm1_rty_o,
   input  logic                    wbm1_cyc_i,

   // shared slave
   output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                    wbs_we_o,
   output logic [SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                    wbs_stb_o,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic                    wbs_cyc_o
);

   // -------------------------------------------------------------------------
   // Grant state
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_q,  last_d;     // master granted most recently

   logic   grant0;
   logic   grant1;
   logic   stb_req;             // granted strobe before the watchdog gate
   logic   timeout_hit;         // watchdog fires this cycle

   assign grant0 = (state_q == GRANT0);
   assign grant1 = (state_q == GRANT1);

   // -------------------------------------------------------------------------
   // Next-state / arbitration
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (wbm0_cyc_i && wbm1_cyc_i) begin
               if (ARB_ROUND_ROBIN != 0) begin
                  // Tie goes to whichever master did not have the bus last.
                  state_d = last_q ? GRANT0 : GRANT1;
               end else begin
                  state_d = GRANT0;
               end
            end else if (wbm0_cyc_i) begin
               state_d = GRANT0;
            end else if (wbm1_cyc_i) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            // Grant is locked while cyc stays high. On release the waiting
            // master (if any) takes over; the releasing master's own cyc is
            // low this cycle, so it can only come back via IDLE.
            if (!wbm0_cyc_i) begin
               last_d  = 1'b0;
               state_d = wbm1_cyc_i ? GRANT1 : IDLE;
            end
         end
         GRANT1: begin
            if (!wbm1_cyc_i) begin
               last_d  = 1'b1;
               state_d = wbm0_cyc_i ? GRANT0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;       // master 0 wins the first tie after reset
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // -------------------------------------------------------------------------
   // Request/response routing (combinational from the registered grant)
   // -------------------------------------------------------------------------
   always_comb begin
      wbs_adr_o  = '0;
      wbs_dat_o  = '0;
      wbs_we_o   = 1'b0;
      wbs_sel_o  = '0;
      wbs_cyc_o  = 1'b0;
      stb_req    = 1'b0;
      wbm0_ack_o = 1'b0;
      wbm0_rty_o = 1'b0;
      wbm1_ack_o = 1'b0;
      wbm1_rty_o = 1'b0;
      unique case (state_q)
         GRANT0: begin
            wbs_adr_o  = wbm0_adr_i;
            wbs_dat_o  = wbm0_dat_i;
            wbs_we_o   = wbm0_we_i;
            wbs_sel_o  = wbm0_sel_i;
            wbs_cyc_o  = wbm0_cyc_i;
            // stb qualified by cyc so a master dropping cyc with stb still
            // high cannot leave a dangling strobe on the slave.
            stb_req    = wbm0_cyc_i & wbm0_stb_i;
            wbm0_ack_o = wbs_ack_i;
            wbm0_rty_o = wbs_rty_i;
         end
         GRANT1: begin
            wbs_adr_o  = wbm1_adr_i;
            wbs_dat_o  = wbm1_dat_i;
            wbs_we_o   = wbm1_we_i;
            wbs_sel_o  = wbm1_sel_i;
            wbs_cyc_o  = wbm1_cyc_i;
            stb_req    = wbm1_cyc_i & wbm1_stb_i;
            wbm1_ack_o = wbs_ack_i;
            wbm1_rty_o = wbs_rty_i;
         end
         default: begin
         end
      endcase
   end

   // The watchdog error replaces the strobe for the cycle it fires.
   assign wbs_stb_o  = stb_req & ~timeout_hit;
   assign wbm0_err_o = grant0 & (wbs_err_i | timeout_hit);
   assign wbm1_err_o = grant1 & (wbs_err_i | timeout_hit);

   // Read data goes to both masters; only the granted one sees ack.
   assign wbm0_dat_o = wbs_dat_i;
   assign wbm1_dat_o = wbs_dat_i;

   // -------------------------------------------------------------------------
   // Watchdog
   // -------------------------------------------------------------------------
   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int              WD_W     = $clog2(TIMEOUT + 1);
         localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

         logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
         logic            slv_resp;
         logic            hit;

         assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
         // A real response in the limit cycle wins over the forced error.
         assign hit      = stb_req & ~slv_resp & (wd_cnt_q == WD_LIMIT);

         always_comb begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (!stb_req || slv_resp || hit || (state_d != state_q)) begin
               wd_cnt_d = '0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               wd_cnt_q <= '0;
            end else begin
               wd_cnt_q <= wd_cnt_d;
            end
         end

         assign timeout_hit = hit;
      end else begin : g_no_wd
         assign timeout_hit = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wishbone_arbiter_2
//  Purpose  : Self-checking bench for wishbone_arbiter_2. Two instances share
//             the same stimulus: dut_a (round-robin, TIMEOUT=16) and dut_b
//             (fixed priority, no watchdog). Expected grant addresses are
//             queued when requests are raised and popped by a monitor on each
//             rising wbs_cyc_o.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_arbiter_2;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW-1:0] m0_dat, m1_dat;
   logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
   logic [SW-1:0] m0_sel, m1_sel;
   logic [DW-1:0] s_dat;
   logic          s_ack, s_err, s_rty;

   // dut_a outputs
   logic [DW-1:0] a_m0_dat, a_m1_dat, a_wdat;
   logic          a_m0_ack, a_m0_err, a_m0_rty, a_m1_ack, a_m1_err, a_m1_rty;
   logic [AW-1:0] a_adr;
   logic          a_we, a_stb, a_cyc;
   logic [SW-1:0] a_sel;
   // dut_b outputs
   logic [DW-1:0] b_m0_dat, b_m1_dat, b_wdat;
   logic          b_m0_ack, b_m0_err, b_m0_rty, b_m1_ack, b_m1_err, b_m1_rty;
   logic [AW-1:0] b_adr;
   logic          b_we, b_stb, b_cyc;
   logic [SW-1:0] b_sel;

   wishbone_arbiter_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                        .ARB_ROUND_ROBIN(1), .TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst),
      .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(a_m0_dat),
      .wbm0_we_i(m0_we), .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb),
      .wbm0_ack_o(a_m0_ack), .wbm0_err_o(a_m0_err), .wbm0_rty_o(a_m0_rty),
      .wbm0_cyc_i(m0_cyc),
      .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(a_m1_dat),
      .wbm1_we_i(m1_we), .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb),
      .wbm1_ack_o(a_m1_ack), .wbm1_err_o(a_m1_err), .wbm1_rty_o(a_m1_rty),
      .wbm1_cyc_i(m1_cyc),
      .wbs_adr_o(a_adr), .wbs_dat_i(s_dat), .wbs_dat_o(a_wdat),
      .wbs_we_o(a_we), .wbs_sel_o(a_sel), .wbs_stb_o(a_stb),
      .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .wbs_cyc_o(a_cyc)
   );

   wishbone_arbiter_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                        .ARB_ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
      .clk(clk), .rst(rst),
      .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(b_m0_dat),
      .wbm0_we_i(m0_we), .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb),
      .wbm0_ack_o(b_m0_ack), .wbm0_err_o(b_m0_err), .wbm0_rty_o(b_m0_rty),
      .wbm0_cyc_i(m0_cyc),
      .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(b_m1_dat),
      .wbm1_we_i(m1_we), .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb),
      .wbm1_ack_o(b_m1_ack), .wbm1_err_o(b_m1_err), .wbm1_rty_o(b_m1_rty),
      .wbm1_cyc_i(m1_cyc),
      .wbs_adr_o(b_adr), .wbs_dat_i(s_dat), .wbs_dat_o(b_wdat),
      .wbs_we_o(b_we), .wbs_sel_o(b_sel), .wbs_stb_o(b_stb),
      .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .wbs_cyc_o(b_cyc)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // expected address of each new slave cycle, per instance
   logic [31:0] sb_a[$];
   logic [31:0] sb_b[$];
   logic        a_cyc_prev = 1'b0;
   logic        b_cyc_prev = 1'b0;

   always @(negedge clk) begin
      if (a_cyc && !a_cyc_prev) begin
         if (sb_a.size() == 0) check("a_grant_unexpected", 64'(sb_a.size()), 64'd1);
         else check("a_grant_adr", 64'(a_adr), 64'(sb_a.pop_front()));
      end
      if (b_cyc && !b_cyc_prev) begin
         if (sb_b.size() == 0) check("b_grant_unexpected", 64'(sb_b.size()), 64'd1);
         else check("b_grant_adr", 64'(b_adr), 64'(sb_b.pop_front()));
      end
      a_cyc_prev <= a_cyc;
      b_cyc_prev <= b_cyc;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // One arbitration from IDLE: raise requests, ack one beat, drop both.
   task automatic contend(input bit r0, input bit r1, input bit ea, input bit eb,
                          input logic [15:0] idx);
      logic [31:0] a0, a1;
      a0 = {16'h0000, idx};
      a1 = {16'h1000, idx};
      m0_cyc = r0; m0_stb = r0; m0_adr = a0; m0_we = 1'b0;
      m1_cyc = r1; m1_stb = r1; m1_adr = a1; m1_we = 1'b0;
      sb_a.push_back(ea ? a1 : a0);
      sb_b.push_back(eb ? a1 : a0);
      smp();
      check("ct_idle_cyc_a", 64'(a_cyc), 64'd0);
      step();
      s_ack = 1'b1;
      s_dat = $urandom;
      smp();
      check("ct_ack0_a", 64'(a_m0_ack), 64'(!ea));
      check("ct_ack1_a", 64'(a_m1_ack), 64'(ea));
      check("ct_ack0_b", 64'(b_m0_ack), 64'(!eb));
      check("ct_ack1_b", 64'(b_m1_ack), 64'(eb));
      check("ct_bcast_dat_a", 64'(a_m1_dat), 64'(s_dat));
      step();
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      smp();
      check("ct_rel_cyc_a", 64'(a_cyc), 64'd0);
      check("ct_rel_cyc_b", 64'(b_cyc), 64'd0);
      step();
   endtask

   // Master 0 strobes an unresponsive slave; optional ack in cycle ack_cyc.
   task automatic timeout_run(input int ack_cyc);
      bit fire;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0500;
      sb_a.push_back(32'h0000_0500);
      sb_b.push_back(32'h0000_0500);
      smp();
      step();
      for (int c = 1; c <= 18; c++) begin
         s_ack = (c == ack_cyc);
         fire  = (ack_cyc == 0) && (c == 17);
         smp();
         check($sformatf("wd_err_a_c%0d_k%0d", c, ack_cyc), 64'(a_m0_err), 64'(fire));
         check($sformatf("wd_stb_a_c%0d_k%0d", c, ack_cyc), 64'(a_stb), 64'(!fire));
         if (c == ack_cyc) check("wd_ack_a", 64'(a_m0_ack), 64'd1);
         if (c == 17) check("wd_err_b", 64'(b_m0_err), 64'd0);
         step();
      end
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      smp();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no end, expected finish");
      $fatal(1);
   end

   initial begin
      m0_adr = 32'h1234_5678; m0_dat = 32'h1111_1111; m0_we = 1'b1; m0_sel = 4'hF;
      m1_adr = 32'h1000_0000; m1_dat = 32'h2222_2222; m1_we = 1'b0; m1_sel = 4'h3;
      m0_stb = 1'b0; m0_cyc = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
      s_dat = 32'hCAFE_F00D; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      step();
      step();
      rst = 1'b0;

      // ---- reset / IDLE state: slave port quiet, responses blocked ----
      s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
      smp();
      check("idle_cyc_a", 64'(a_cyc), 64'd0);
      check("idle_stb_a", 64'(a_stb), 64'd0);
      check("idle_adr_a", 64'(a_adr), 64'd0);
      check("idle_wdat_a", 64'(a_wdat), 64'd0);
      check("idle_we_a", 64'(a_we), 64'd0);
      check("idle_sel_a", 64'(a_sel), 64'd0);
      check("idle_ack0_a", 64'(a_m0_ack), 64'd0);
      check("idle_err0_a", 64'(a_m0_err), 64'd0);
      check("idle_rty1_a", 64'(a_m1_rty), 64'd0);
      check("idle_cyc_b", 64'(b_cyc), 64'd0);
      check("idle_adr_b", 64'(b_adr), 64'd0);
      check("idle_dat0_a", 64'(a_m0_dat), 64'hCAFE_F00D);
      step();
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

      // ---- master 0 single read ----
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0100;
      sb_a.push_back(32'h0000_0100);
      sb_b.push_back(32'h0000_0100);
      smp();
      check("rd_latency_cyc_a", 64'(a_cyc), 64'd0);
      step();
      smp();
      check("rd_cyc_a", 64'(a_cyc), 64'd1);
      check("rd_stb_a", 64'(a_stb), 64'd1);
      step();
      smp();
      check("rd_noack_a", 64'(a_m0_ack), 64'd0);
      step();
      s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
      smp();
      check("rd_ack0_a", 64'(a_m0_ack), 64'd1);
      check("rd_dat0_a", 64'(a_m0_dat), 64'hDEAD_BEEF);
      check("rd_ack1_a", 64'(a_m1_ack), 64'd0);
      step();
      m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
      smp();
      check("rd_rel_cyc_a", 64'(a_cyc), 64'd0);
      step();

      // ---- contention: round-robin (a) vs fixed priority (b) ----
      do_reset();
      contend(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200);
      contend(1'b1, 1'b1, 1'b1, 1'b0, 16'h0210);
      contend(1'b1, 1'b1, 1'b0, 1'b0, 16'h0220);
      contend(1'b1, 1'b0, 1'b0, 1'b0, 16'h0230);
      contend(1'b1, 1'b1, 1'b1, 1'b0, 16'h0240);
      contend(1'b0, 1'b1, 1'b1, 1'b1, 16'h0250);

      // ---- lock: master 0 burst of 4 writes while master 1 waits ----
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0010;
      m0_dat = 32'hA000_0000;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h1000_0010;
      sb_a.push_back(32'h0000_0010);
      sb_b.push_back(32'h0000_0010);
      smp();
      step();
      for (int i = 0; i < 4; i++) begin
         m0_adr = 32'h0000_0010 + 32'(4 * i);
         m0_dat = 32'hA000_0000 + 32'(i);
         s_ack  = 1'b1;
         smp();
         check($sformatf("lock_adr_a_%0d", i), 64'(a_adr), 64'(32'h10 + 32'(4 * i)));
         check($sformatf("lock_adr_b_%0d", i), 64'(b_adr), 64'(32'h10 + 32'(4 * i)));
         check($sformatf("lock_wdat_a_%0d", i), 64'(a_wdat), 64'(32'hA000_0000 + 32'(i)));
         check($sformatf("lock_we_a_%0d", i), 64'(a_we), 64'd1);
         check($sformatf("lock_ack1_a_%0d", i), 64'(a_m1_ack), 64'd0);
         step();
      end
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b0;
      sb_a.push_back(32'h1000_0010);
      sb_b.push_back(32'h1000_0010);
      smp();
      check("handover_gap_cyc_a", 64'(a_cyc), 64'd0);
      check("handover_gap_cyc_b", 64'(b_cyc), 64'd0);
      step();
      s_ack = 1'b1;
      smp();
      check("handover_ack1_a", 64'(a_m1_ack), 64'd1);
      check("handover_ack0_a", 64'(a_m0_ack), 64'd0);
      check("handover_ack1_b", 64'(b_m1_ack), 64'd1);
      step();
      m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      smp();
      step();

      // ---- watchdog: no response, ack before limit, ack in limit cycle ----
      timeout_run(0);
      timeout_run(15);
      timeout_run(17);

      // ---- reset while master 1 owns the bus mid-burst ----
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h1000_0600;
      sb_a.push_back(32'h1000_0600);
      sb_b.push_back(32'h1000_0600);
      smp();
      step();
      s_ack = 1'b1;
      smp();
      check("rst_pre_ack1_a", 64'(a_m1_ack), 64'd1);
      step();
      rst = 1'b1; m1_adr = 32'h1000_0604;
      smp();
      check("rst_pre_cyc_a", 64'(a_cyc), 64'd1);
      step();
      rst = 1'b0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0700;
      sb_a.push_back(32'h0000_0700);
      sb_b.push_back(32'h0000_0700);
      smp();
      check("rst_post_cyc_a", 64'(a_cyc), 64'd0);
      check("rst_post_stb_a", 64'(a_stb), 64'd0);
      check("rst_post_ack1_a", 64'(a_m1_ack), 64'd0);
      check("rst_post_cyc_b", 64'(b_cyc), 64'd0);
      step();
      smp();
      check("rst_tie_ack0_a", 64'(a_m0_ack), 64'd1);
      check("rst_tie_ack1_a", 64'(a_m1_ack), 64'd0);
      step();
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      smp();
      step();
      step();

      check("sb_a_drained", 64'(sb_a.size()), 64'd0);
      check("sb_b_drained", 64'(sb_b.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
